// File: rtl/avalon_input_port.sv
// Avalon-MM input PIO for the board's slider switches and pushbuttons.
// Pins are synchronized and debounced; switch changes and key presses are latched as maskable events.
module avalon_input_port #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_SW          = 10,
    parameter int NUM_KEY         = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SW-1:0]  sw,
    input  logic [NUM_KEY-1:0] key,
    input  logic [1:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    output logic [31:0]        avs_readdata,
    output logic               irq
);

    localparam int NUM_IN = NUM_SW + NUM_KEY;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [31:0]      SW_BITS   = (32'd1 << NUM_SW) - 32'd1;
    localparam logic [31:0]      KEY_BITS  = ((32'd1 << NUM_KEY) - 32'd1) << 16;
    localparam logic [31:0]      IMPL_BITS = SW_BITS | KEY_BITS;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_EVENT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // Internal vectors are {keys, switches}; this places them at the register layout.
    function automatic logic [31:0] to_word(input logic [NUM_IN-1:0] v);
        logic [31:0] w;
        w = 32'(v[NUM_SW-1:0]) | (32'(v[NUM_IN-1:NUM_SW]) << 16);
        return w;
    endfunction

    logic [NUM_SW-1:0]  sw_meta;
    logic [NUM_SW-1:0]  sw_sync;
    logic [NUM_KEY-1:0] key_meta;
    logic [NUM_KEY-1:0] key_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= '1;
            key_sync <= '1;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    logic [NUM_IN-1:0] in_sync;
    logic [NUM_IN-1:0] stable;
    logic [NUM_IN-1:0] pending;
    logic [NUM_IN-1:0] accept;
    logic [NUM_IN-1:0] set_vec;
    logic [CNT_W-1:0]  cnt [NUM_IN];
    logic              busy;

    assign in_sync = {~key_sync, sw_sync};

    always_comb begin
        pending = '0;
        accept  = '0;
        busy    = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            pending[i] = (in_sync[i] != stable[i]);
            accept[i]  = pending[i] && (cnt[i] == CNT_LAST);
            busy       = busy | (cnt[i] != '0);
        end
    end

    // Switches flag any accepted change; keys flag only an accepted press (new value 1).
    assign set_vec = {accept[NUM_IN-1:NUM_SW] & in_sync[NUM_IN-1:NUM_SW],
                      accept[NUM_SW-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable <= stable ^ accept;
            for (int i = 0; i < NUM_IN; i++) begin
                if (!pending[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    logic [31:0] stable_word;
    logic [31:0] set_word;
    logic [31:0] mask_q;
    logic [31:0] event_q;
    logic [31:0] event_clr;
    logic        wr_mask;
    logic        wr_event;

    assign stable_word = to_word(stable);
    assign set_word    = to_word(set_vec);
    assign wr_mask     = avs_write && (avs_address == ADDR_MASK);
    assign wr_event    = avs_write && (avs_address == ADDR_EVENT);
    assign event_clr   = wr_event ? (avs_writedata & IMPL_BITS) : 32'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q       <= '0;
            event_q      <= '0;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            if (wr_mask) begin
                mask_q <= avs_writedata & IMPL_BITS;
            end
            // A set arriving in the same cycle as a clear keeps the flag.
            event_q <= (event_q & ~event_clr) | set_word;
            irq     <= |(event_q & mask_q);
            if (avs_read) begin
                case (avs_address)
                    ADDR_DATA:   avs_readdata <= stable_word;
                    ADDR_MASK:   avs_readdata <= mask_q;
                    ADDR_EVENT:  avs_readdata <= event_q;
                    ADDR_STATUS: avs_readdata <= {30'd0, busy, irq};
                    default:     avs_readdata <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_avalon_input_port.sv
// Directed + randomized bench for avalon_input_port against a sample-window reference model.
module tb_avalon_input_port;

    localparam int DEB     = 4;
    localparam int NSW     = 10;
    localparam int NKEY    = 4;
    localparam logic [31:0] SWB  = 32'h0000_03FF;
    localparam logic [31:0] KEYB = 32'h000F_0000;
    localparam logic [31:0] IMPL = SWB | KEYB;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic [NSW-1:0]  sw = '0;
    logic [NKEY-1:0] key = '1;
    logic [1:0]      avs_address = '0;
    logic            avs_read = 1'b0;
    logic            avs_write = 1'b0;
    logic [31:0]     avs_writedata = '0;
    logic [31:0]     avs_readdata;
    logic            irq;

    int checks = 0;
    int errors = 0;

    avalon_input_port #(
        .DEBOUNCE_CYCLES(DEB),
        .NUM_SW(NSW),
        .NUM_KEY(NKEY)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sw(sw),
        .key(key),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: a bit becomes stable at a new level once the last DEB
    // pin samples that reached the synchronizer output all disagree with it.
    logic [31:0] raw_word;
    logic [31:0] hist [0:DEB];
    logic [31:0] m_stable, m_event, m_mask, m_rd;
    logic        m_irq, m_busy;
    logic [31:0] m_upd, m_stable_n, m_set, m_clr, m_event_n, m_mask_n, m_rd_n;
    logic        m_busy_n;

    assign raw_word = {12'd0, ~key, 6'd0, sw};

    always_comb begin
        m_upd = IMPL;
        for (int k = 1; k <= DEB; k++) begin
            m_upd = m_upd & (hist[k] ^ m_stable);
        end
        m_stable_n = m_stable ^ m_upd;
        m_set      = (m_upd & SWB) | (m_upd & m_stable_n & KEYB);
        m_busy_n   = |((hist[1] ^ m_stable) & IMPL & ~m_upd);
        m_clr      = (avs_write && avs_address == 2'd2) ? avs_writedata : 32'd0;
        m_event_n  = (m_event & ~m_clr) | m_set;
        m_mask_n   = (avs_write && avs_address == 2'd1) ? (avs_writedata & IMPL) : m_mask;
        m_rd_n     = m_rd;
        if (avs_read) begin
            case (avs_address)
                2'd0:    m_rd_n = m_stable;
                2'd1:    m_rd_n = m_mask;
                2'd2:    m_rd_n = m_event;
                default: m_rd_n = {30'd0, m_busy, m_irq};
            endcase
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= DEB; k++) hist[k] <= '0;
            m_stable <= '0;
            m_event  <= '0;
            m_mask   <= '0;
            m_rd     <= '0;
            m_irq    <= 1'b0;
            m_busy   <= 1'b0;
        end else begin
            for (int k = 1; k <= DEB; k++) hist[k] <= hist[k-1];
            hist[0]  <= raw_word;
            m_stable <= m_stable_n;
            m_event  <= m_event_n;
            m_mask   <= m_mask_n;
            m_rd     <= m_rd_n;
            m_irq    <= |(m_event & m_mask);
            m_busy   <= m_busy_n;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("model_readdata", avs_readdata, m_rd);
        chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic do_read(input logic [1:0] addr, output logic [31:0] d);
        avs_address = addr;
        avs_read    = 1'b1;
        tick();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [31:0] d;
        int b;

        #2 reset_n = 1'b0;
        #1;
        chk("reset_readdata", avs_readdata, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // 1: idle register values
        for (int a = 0; a < 4; a++) begin
            do_read(2'(a), d);
            chk("idle_read", d, 32'd0);
        end
        chk("idle_irq", {31'd0, irq}, 32'd0);

        // 2: switch change latency, irq held off by MASK
        sw[3] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            do_read(2'd0, d);
            if (i == 6) chk("sw3_data_before", d, 32'h0);
            if (i == 7) chk("sw3_data_after", d, 32'h8);
        end
        do_read(2'd2, d);
        chk("sw3_event", d, 32'h8);
        chk("sw3_irq_masked", {31'd0, irq}, 32'd0);

        // 3: short key glitch rejected, held press accepted
        key[1] = 1'b0;
        ticks(3);
        key[1] = 1'b1;
        ticks(8);
        do_read(2'd0, d);
        chk("glitch_data", d, 32'h8);
        do_read(2'd2, d);
        chk("glitch_event", d, 32'h8);
        chk("glitch_irq", {31'd0, irq}, 32'd0);
        key[1] = 1'b0;
        ticks(8);
        do_read(2'd2, d);
        chk("key1_event", d, 32'h2_0008);
        do_read(2'd0, d);
        chk("key1_data", d, 32'h2_0008);
        do_write(2'd1, 32'h2_0000);
        chk("irq_not_yet", {31'd0, irq}, 32'd0);
        tick();
        chk("irq_raised", {31'd0, irq}, 32'd1);

        // 4: W1C clear drops irq next clock; release makes no event
        do_write(2'd2, 32'h2_0000);
        tick();
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        do_read(2'd2, d);
        chk("event_after_clr", d, 32'h8);
        key[1] = 1'b1;
        ticks(8);
        do_read(2'd2, d);
        chk("release_no_event", d, 32'h8);
        do_read(2'd0, d);
        chk("release_data", d, 32'h8);

        // 5: clear coincident with a new sw[3] acceptance
        sw[3] = 1'b0;
        ticks(5);
        do_write(2'd2, 32'h8);
        do_read(2'd2, d);
        chk("set_wins_event", d, 32'h8);
        do_read(2'd0, d);
        chk("set_wins_data", d, 32'h0);
        do_write(2'd2, 32'h8);
        do_read(2'd2, d);
        chk("plain_clear", d, 32'h0);
        sw[3] = 1'b1;
        ticks(8);

        // 6: reset with sw[5] mid-debounce
        sw[5] = 1'b1;
        ticks(3);
        do_read(2'd3, d);
        chk("status_busy", d, 32'h2);
        reset_n = 1'b0;
        #1;
        chk("midrst_readdata", avs_readdata, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            do_read(2'd0, d);
            if (i == 6) chk("post_rst_before", d, 32'h0);
            if (i == 7) chk("post_rst_after", d, 32'h28);
        end
        do_read(2'd2, d);
        chk("post_rst_event", d, 32'h28);
        do_read(2'd1, d);
        chk("post_rst_mask", d, 32'h0);

        // Randomized traffic against the model
        do_write(2'd2, 32'hFFFF_FFFF);
        for (int it = 0; it < 2000; it++) begin
            if ($urandom_range(2) == 0) begin
                b = int'($urandom_range(13));
                if (b < NSW) sw[b] = ~sw[b];
                else         key[b-NSW] = ~key[b-NSW];
            end
            case ($urandom_range(3))
                0: tick();
                1: do_read(2'($urandom_range(3)), d);
                2: do_write(2'($urandom_range(3)), $urandom & $urandom);
                default: do_write(2'd1, $urandom);
            endcase
        end
        ticks(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
